// File: rtl/rv32_pkg.sv
// Shared rv32 definitions for the register scoreboard: opcodes, result
// classes, forwarding select codes and the pipeline slot record.
package rv32_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        CLS_NONE = 2'b00,
        CLS_ALU  = 2'b01,
        CLS_PC4  = 2'b10,
        CLS_LOAD = 2'b11
    } cls_t;

    typedef enum logic [1:0] {
        FWD_RF      = 2'b00,
        FWD_EXE     = 2'b01,
        FWD_ACC_ALU = 2'b10,
        FWD_ACC_MEM = 2'b11
    } fwd_sel_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        cls_t       cls;
    } slot_t;

    // A slot only produces a value worth tracking when it is valid and writes a real register.
    function automatic logic slot_live(slot_t s);
        return s.valid && (s.cls != CLS_NONE);
    endfunction

    function automatic logic slot_hit(slot_t s, logic used, logic [4:0] rs);
        return used && slot_live(s) && (s.rd == rs);
    endfunction

    function automatic logic [31:0] slot_onehot(slot_t s);
        return slot_live(s) ? (32'd1 << s.rd) : 32'd0;
    endfunction

    // Newest producer wins; a load still in exe has no data yet, so the stall covers it.
    function automatic fwd_sel_t fwd_select(logic exe_hit, logic acc_hit, slot_t exe, slot_t acc);
        if (exe_hit)
            return (exe.cls == CLS_LOAD) ? FWD_RF : FWD_EXE;
        else if (acc_hit)
            return (acc.cls == CLS_LOAD) ? FWD_ACC_MEM : FWD_ACC_ALU;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/instr_classify.sv
// Decodes an rv32 instruction word into its destination register, result
// class and which source operands it actually reads.
module instr_classify
    import rv32_pkg::*;
(
    input  logic [31:0] instr,
    output logic [4:0]  rd,
    output logic [1:0]  cls,
    output logic        uses_rs1,
    output logic        uses_rs2
);

    logic [6:0] opcode;
    cls_t       cls_c;
    logic       unused_fields;

    assign opcode        = instr[6:0];
    assign rd            = instr[11:7];
    assign cls           = cls_c;
    assign unused_fields = ^instr[31:12];

    // Class and operand usage by opcode; writes to x0 are never tracked.
    always_comb begin
        cls_c    = CLS_NONE;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC, OP_IMM, OP_REG: cls_c = CLS_ALU;
            OP_JAL, OP_JALR:                  cls_c = CLS_PC4;
            OP_LOAD:                          cls_c = CLS_LOAD;
            default:                          cls_c = CLS_NONE;
        endcase
        if (rd == 5'd0)
            cls_c = CLS_NONE;
        if (opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL)
            uses_rs1 = 1'b0;
        if (opcode == OP_REG || opcode == OP_STORE || opcode == OP_BRANCH)
            uses_rs2 = 1'b1;
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Producer-side register scoreboard for the rv32 pipeline. Tracks writes in
// the exe/acc/wb stages and publishes forwarding selects, a load-use stall
// and a busy map for the instruction in decode.
// Build option REG_SB_FWD_EN: when defined, operands are forwarded from exe
// and acc; when undefined, selects are tied to the regfile and any exe/acc
// producer stalls decode instead.
module reg_scoreboard
    import rv32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    input  logic [31:0] instr_de,
    input  logic        hold,
    input  logic        flush,
    output logic        stall,
    output logic [1:0]  fwd_a_sel,
    output logic [1:0]  fwd_b_sel,
    output logic [31:0] busy_map
);

    logic [4:0] dec_rd;
    logic [1:0] dec_cls;
    logic       uses_rs1;
    logic       uses_rs2;
    logic [4:0] rs1;
    logic [4:0] rs2;
    slot_t      exe_q;
    slot_t      acc_q;
    slot_t      wb_q;
    logic       a_exe;
    logic       a_acc;
    logic       b_exe;
    logic       b_acc;
    logic       entry_valid;

    instr_classify u_decode_class (
        .instr    (instr_de),
        .rd       (dec_rd),
        .cls      (dec_cls),
        .uses_rs1 (uses_rs1),
        .uses_rs2 (uses_rs2)
    );

    assign rs1   = instr_de[19:15];
    assign rs2   = instr_de[24:20];
    assign a_exe = slot_hit(exe_q, uses_rs1, rs1);
    assign a_acc = slot_hit(acc_q, uses_rs1, rs1);
    assign b_exe = slot_hit(exe_q, uses_rs2, rs2);
    assign b_acc = slot_hit(acc_q, uses_rs2, rs2);

    assign entry_valid = issue_valid & ~stall & ~flush;

`ifdef REG_SB_FWD_EN
    // Only a load sitting in exe forces a bubble; everything else is forwarded.
    always_comb begin
        stall     = issue_valid & ~flush &
                    ((a_exe & (exe_q.cls == CLS_LOAD)) | (b_exe & (exe_q.cls == CLS_LOAD)));
        fwd_a_sel = issue_valid ? fwd_select(a_exe, a_acc, exe_q, acc_q) : FWD_RF;
        fwd_b_sel = issue_valid ? fwd_select(b_exe, b_acc, exe_q, acc_q) : FWD_RF;
    end
`else
    // Without forwarding every exe/acc producer must drain to wb before decode proceeds.
    always_comb begin
        stall     = issue_valid & ~flush & (a_exe | a_acc | b_exe | b_acc);
        fwd_a_sel = FWD_RF;
        fwd_b_sel = FWD_RF;
    end
`endif

    // Busy map is the union of live destinations; x0 can never be busy.
    always_comb begin
        busy_map = (slot_onehot(exe_q) | slot_onehot(acc_q) | slot_onehot(wb_q)) & ~32'd1;
    end

    // Age slots down the pipe; hold freezes them, but flush still kills exe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exe_q <= '{valid: 1'b0, rd: 5'd0, cls: CLS_NONE};
            acc_q <= '{valid: 1'b0, rd: 5'd0, cls: CLS_NONE};
            wb_q  <= '{valid: 1'b0, rd: 5'd0, cls: CLS_NONE};
        end else if (hold) begin
            if (flush)
                exe_q.valid <= 1'b0;
        end else begin
            wb_q  <= acc_q;
            acc_q <= exe_q;
            exe_q <= '{valid: entry_valid, rd: dec_rd, cls: cls_t'(dec_cls)};
        end
    end

endmodule
